spi_mem_ctrl: RTL and testbench

//  Command decoder and storage downstream of the SPI slave.
//  - Consumes each 10-bit word the slave deserialises (din + rx_valid).
//  - Stores write data into a MEM_DEPTH x 8 array.
//  - Returns read data as an 8-bit word with a one-cycle tx_valid strobe;
//    the slave then serialises that word onto MISO.

---
 rtl/spi_mem_pkg.sv | 18 +
 rtl/spi_mem_array.sv | 31 +++
 rtl/spi_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_spi_mem_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory controller slice.
// Contents:
//   op_e    command opcode carried in din[9:8]
//   CMD_W   width of a deserialised command word
//   DATA_W  width of a data byte / array word
package spi_mem_pkg;

    localparam int unsigned CMD_W  = 10;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

endpackage

// File: rtl/spi_mem_array.sv
// Synchronous single-port MEM_DEPTH x DATA_W RAM with registered read.
// Ports:
//   clk    in   clock, all activity on rising edge
//   we     in   write enable, writes wdata to addr
//   addr   in   word address (always < MEM_DEPTH when driven by the controller)
//   wdata  in   write data
//   rdata  out  registered read data: mem[addr] as sampled at the last edge
// Contents are not reset.
module spi_mem_array
    import spi_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Command decoder and storage behind the SPI slave.
// Each valid 10-bit word is decoded as {opcode, payload}: address loads arm the
// write/read pointers, data commands write the array or return one byte.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   din       in   command word: [9:8] opcode, [7:0] payload
//   rx_valid  in   din valid this cycle
//   dout      out  read data, held until the next successful read
//   tx_valid  out  one-cycle pulse, dout carries a new read word
//   err       out  one-cycle pulse, data command before its address was loaded
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err
);

    // Reduce an address to the populated range; also wraps pointer increments.
    function automatic logic [ADDR_SIZE-1:0] wrap_addr(input logic [ADDR_SIZE:0] a);
        return ADDR_SIZE'(32'(a) % MEM_DEPTH);
    endfunction

    op_e                  op;
    logic [ADDR_SIZE-1:0] cmd_addr;

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic                 wr_armed_q, wr_armed_d;
    logic                 rd_armed_q, rd_armed_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    dout_q, dout_d;

    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    assign op       = op_e'(din[CMD_W-1:CMD_W-2]);
    assign cmd_addr = wrap_addr({1'b0, din[ADDR_SIZE-1:0]});

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        tx_valid_d = 1'b0;
        err_d      = 1'b0;
        // The RAM presents a read word for exactly the tx_valid cycle; latch it
        // then so dout keeps it after rdata moves on.
        dout_d     = tx_valid_q ? mem_rdata : dout_q;
        mem_we     = 1'b0;
        mem_addr   = rd_ptr_q;
        mem_wdata  = din[DATA_W-1:0];

        if (rx_valid) begin
            unique case (op)
                OP_WR_ADDR: begin
                    wr_ptr_d   = cmd_addr;
                    wr_armed_d = 1'b1;
                end
                OP_WR_DATA: begin
                    if (wr_armed_q) begin
                        mem_we   = 1'b1;
                        mem_addr = wr_ptr_q;
                        wr_ptr_d = wrap_addr({1'b0, wr_ptr_q} + (ADDR_SIZE + 1)'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    rd_ptr_d   = cmd_addr;
                    rd_armed_d = 1'b1;
                end
                OP_RD_DATA: begin
                    if (rd_armed_q) begin
                        tx_valid_d = 1'b1;
                        rd_ptr_d   = wrap_addr({1'b0, rd_ptr_q} + (ADDR_SIZE + 1)'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_armed_q <= 1'b0;
            rd_armed_q <= 1'b0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_armed_q <= wr_armed_d;
            rd_armed_q <= rd_armed_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
        end
    end

    spi_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // During a read-return cycle the freshly read word is forwarded directly.
    assign dout     = tx_valid_q ? mem_rdata : dout_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: directed scenarios plus a randomized
// command stream checked against a behavioural model of the command set.
module tb_spi_mem_ctrl;

    localparam int unsigned DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mem_m [DEPTH];
    int         wp, rp;
    bit         warm, rarm;
    logic [7:0] exp_dout;
    logic       exp_tx, exp_err;

    always #5 clk = ~clk;

    spi_mem_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .err      (err)
    );

    task automatic model_reset();
        wp = 0; rp = 0; warm = 0; rarm = 0;
        exp_dout = 8'h00; exp_tx = 0; exp_err = 0;
    endtask

    // Called at a negedge: present one cycle of input, let the posedge consume
    // it, return at the next negedge with the model advanced.
    task automatic step(input bit v, input logic [9:0] d);
        rx_valid = v;
        din = d;
        @(negedge clk);
        rx_valid = 1'b0;
        exp_tx = 0;
        exp_err = 0;
        if (v) begin
            case (d[9:8])
                2'b00: begin wp = int'(d[7:0]) % DEPTH; warm = 1; end
                2'b01: begin
                    if (warm) begin mem_m[wp] = d[7:0]; wp = (wp + 1) % DEPTH; end
                    else exp_err = 1;
                end
                2'b10: begin rp = int'(d[7:0]) % DEPTH; rarm = 1; end
                default: begin
                    if (rarm) begin exp_dout = mem_m[rp]; exp_tx = 1; rp = (rp + 1) % DEPTH; end
                    else exp_err = 1;
                end
            endcase
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        checks++;
        if (dout !== 8'h00 || tx_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: dout=%h tx=%b err=%b expected 00/0/0", dout, tx_valid, err);
        end
        rst_n = 1'b1;
        model_reset();
        // Build up a read so tx_valid is high, then reset asynchronously.
        step(1, 10'h040); step(1, 10'h15A); step(1, 10'h240); step(1, 10'h300);
        checks++;
        if (dout !== 8'h5A || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_preread: dout=%h tx=%b expected 5a/1", dout, tx_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || tx_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: dout=%h tx=%b err=%b expected 00/0/0", dout, tx_valid, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 10'h300);
        checks++;
        if (err !== 1'b1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_unarmed: err=%b tx=%b expected 1/0", err, tx_valid);
        end
    endtask

    task automatic test_write_readback();
        step(1, 10'h012); step(1, 10'h1A5); step(1, 10'h212); step(1, 10'h300);
        checks++;
        if (dout !== 8'hA5 || tx_valid !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd: dout=%h tx=%b err=%b expected a5/1/0", dout, tx_valid, err);
        end
        step(0, 10'h000);
        checks++;
        if (dout !== 8'hA5 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_hold: dout=%h tx=%b expected a5/0", dout, tx_valid);
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] want [3];
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
        step(1, 10'h0FE); step(1, 10'h111); step(1, 10'h122); step(1, 10'h133);
        step(1, 10'h2FE);
        for (int i = 0; i < 3; i++) begin
            step(1, 10'h3FF);
            checks++;
            if (dout !== want[i] || tx_valid !== 1'b1) begin
                failures++;
                $display("FAIL burst_wrap[%0d]: dout=%h tx=%b expected %h/1", i, dout, tx_valid,
                         want[i]);
            end
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        step(1, 10'h1EE);
        checks++;
        if (err !== 1'b1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL perr_wr: err=%b tx=%b expected 1/0", err, tx_valid);
        end
        step(0, 10'h000);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL perr_pulse: err=%b expected 0", err);
        end
        step(1, 10'h3C0);
        checks++;
        if (err !== 1'b1 || tx_valid !== 1'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL perr_rd: err=%b tx=%b dout=%h expected 1/0/00", err, tx_valid, dout);
        end
        // Address 0x00 still holds 0x33 from the wrap burst.
        step(1, 10'h200); step(1, 10'h300);
        checks++;
        if (dout !== 8'h33 || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL perr_mem: dout=%h tx=%b expected 33/1", dout, tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 10'h080); step(1, 10'h280);
        step(1, 10'h1C3); step(1, 10'h300);
        checks++;
        if (dout !== 8'hC3 || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b: dout=%h tx=%b expected c3/1", dout, tx_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 10'($urandom));
            checks++;
            if (dout !== 8'hC3 || tx_valid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL gap[%0d]: dout=%h tx=%b err=%b expected c3/0/0", i, dout,
                         tx_valid, err);
            end
        end
        step(1, 10'h17E); step(0, 10'h2AA); step(1, 10'h300);
        checks++;
        if (dout !== 8'h7E || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL gap_read: dout=%h tx=%b expected 7e/1", dout, tx_valid);
        end
    endtask

    task automatic test_random();
        int printed = 0;
        do_reset();
        // Fill the whole array so every later read has a defined expectation.
        step(1, 10'h000);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, {2'b01, 8'($urandom)});
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL fill[%0d]: err=%b expected 0", i, err);
            end
        end
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 10'($urandom));
            checks++;
            if (dout !== exp_dout || tx_valid !== exp_tx || err !== exp_err) begin
                failures++;
                if (printed < 10) begin
                    printed++;
                    $display("FAIL random[%0d]: dout=%h tx=%b err=%b expected %h/%b/%b", i, dout,
                             tx_valid, err, exp_dout, exp_tx, exp_err);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_readback();
        test_burst_wrap();
        test_protocol_error();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
